// File: rtl/fft_stage_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_stage_sequencer_pkg -- shared FFT sizing constants and sequencer states
// Rev 1.0
// ----------------------------------------------------------------------------
package fft_stage_sequencer_pkg;

    localparam int unsigned FFT_N       = 256;
    localparam int unsigned FFT_SIZE    = 8;
    localparam int unsigned FFT_STAGES  = FFT_SIZE;
    localparam int unsigned FFT_TIMEOUT = 1024;

    typedef enum logic [5:0] {
        ST_IDLE     = 6'b000001,
        ST_LOAD     = 6'b000010,
        ST_RUN      = 6'b000100,
        ST_WAIT_STG = 6'b001000,
        ST_UNLOAD   = 6'b010000,
        ST_DONE     = 6'b100000
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_stage_sequencer_unload.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_unload_cnt -- natural-order result address generator with stall and wrap
// Rev 1.0
// ----------------------------------------------------------------------------
module fft_unload_cnt
    import fft_stage_sequencer_pkg::*;
#(
    parameter int unsigned N    = FFT_N,
    parameter int unsigned SIZE = FFT_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            ready_i,
    output logic [SIZE-1:0] addr_o,
    output logic            valid_o,
    output logic            last_o
);

    logic [SIZE-1:0] addr_q, addr_d;

    always_comb begin
        valid_o = en_i & ready_i;
        last_o  = valid_o && (addr_q == SIZE'(N - 1));
        addr_d  = addr_q;
        if (clr_i) begin
            addr_d = '0;
        end else if (last_o) begin
            addr_d = '0;
        end else if (valid_o) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule
`default_nettype wire

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fft_stage_sequencer -- frame controller: load, STAGES ping-pong passes, unload
// Rev 1.0
// ----------------------------------------------------------------------------
module fft_stage_sequencer
    import fft_stage_sequencer_pkg::*;
#(
    parameter int unsigned N       = FFT_N,
    parameter int unsigned SIZE    = FFT_SIZE,
    parameter int unsigned STAGES  = FFT_STAGES,
    parameter int unsigned TIMEOUT = FFT_TIMEOUT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic            load_done_i,
    input  logic            stage_done_i,
    input  logic            unload_ready_i,
    output logic            load_en_o,
    output logic            stage_start_o,
    output logic [2:0]      stage_idx_o,
    output logic            bank_sel_o,
    output logic            unload_en_o,
    output logic [SIZE-1:0] unload_addr_o,
    output logic            unload_valid_o,
    output logic            busy_o,
    output logic            frame_done_o,
    output logic            overrun_o,
    output logic            timeout_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    seq_state_e       state_q, state_d;
    logic [2:0]       stage_idx_q, stage_idx_d;
    logic             bank_sel_q, bank_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;
    logic             unload_last;
    logic             unload_clr;

    // cnt_q holds the number of cycles since the current stage_start_o (0 in RUN)
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        bank_sel_d  = bank_sel_q;
        cnt_d       = cnt_q;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        if (abort_i) begin
            state_d = ST_IDLE;
        end else begin
            if (start_i) begin
                if (state_q == ST_IDLE) begin
                    overrun_d = 1'b0;
                    timeout_d = 1'b0;
                end else begin
                    overrun_d = 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d     = ST_LOAD;
                        stage_idx_d = '0;
                        bank_sel_d  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_done_i) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end
                end
                ST_RUN: begin
                    state_d = ST_WAIT_STG;
                    cnt_d   = cnt_q + 1'b1;
                end
                ST_WAIT_STG: begin
                    cnt_d = cnt_q + 1'b1;
                    // A completion arriving on the timeout cycle still wins
                    if (stage_done_i) begin
                        bank_sel_d = ~bank_sel_q;
                        if (stage_idx_q == 3'(STAGES - 1)) begin
                            state_d = ST_UNLOAD;
                        end else begin
                            stage_idx_d = stage_idx_q + 3'd1;
                            state_d     = ST_RUN;
                            cnt_d       = '0;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                ST_UNLOAD: begin
                    if (unload_last) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_idx_q <= '0;
            bank_sel_q  <= 1'b0;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            bank_sel_q  <= bank_sel_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // Restart the address on abort and on every accepted start so a new frame begins at 0
    assign unload_clr = abort_i | ((state_q == ST_IDLE) & start_i);

    fft_unload_cnt #(
        .N    (N),
        .SIZE (SIZE)
    ) u_unload_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (unload_clr),
        .en_i    (state_q == ST_UNLOAD),
        .ready_i (unload_ready_i),
        .addr_o  (unload_addr_o),
        .valid_o (unload_valid_o),
        .last_o  (unload_last)
    );

    assign load_en_o     = (state_q == ST_LOAD);
    assign stage_start_o = (state_q == ST_RUN);
    assign unload_en_o   = (state_q == ST_UNLOAD);
    assign frame_done_o  = (state_q == ST_DONE);
    assign busy_o        = (state_q != ST_IDLE);
    assign stage_idx_o   = stage_idx_q;
    assign bank_sel_o    = bank_sel_q;
    assign overrun_o     = overrun_q;
    assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_stage_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fft_stage_sequencer -- scoreboard bench: stage order, unload addresses, frame timing
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fft_stage_sequencer;

    localparam int N       = 256;
    localparam int STAGES  = 8;
    localparam int TIMEOUT = 1024;
    localparam int LS      = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       load_done_i = 1'b0;
    logic       stage_done_i = 1'b0;
    logic       unload_ready_i = 1'b0;
    logic       load_en_o;
    logic       stage_start_o;
    logic [2:0] stage_idx_o;
    logic       bank_sel_o;
    logic       unload_en_o;
    logic [7:0] unload_addr_o;
    logic       unload_valid_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       overrun_o;
    logic       timeout_o;

    fft_stage_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .load_done_i    (load_done_i),
        .stage_done_i   (stage_done_i),
        .unload_ready_i (unload_ready_i),
        .load_en_o      (load_en_o),
        .stage_start_o  (stage_start_o),
        .stage_idx_o    (stage_idx_o),
        .bank_sel_o     (bank_sel_o),
        .unload_en_o    (unload_en_o),
        .unload_addr_o  (unload_addr_o),
        .unload_valid_o (unload_valid_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .overrun_o      (overrun_o),
        .timeout_o      (timeout_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int load_cyc = 0;
    int last_start_cyc = 0;
    int unl_cycles = 0;
    int n_done = 0;
    int resp_cnt = 0;
    int hold_stage = -1;
    bit bp_mode = 1'b0;
    bit rdy_phase = 1'b0;
    int stage_q[$];
    int addr_q[$];
    int done_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [20:0] all_outs();
        return {load_en_o, stage_start_o, stage_idx_o, bank_sel_o, unload_en_o, unload_addr_o,
                unload_valid_o, busy_o, frame_done_o, overrun_o, timeout_o};
    endfunction

    // One clock: drive the stage/unload responders for this cycle, then score the outputs.
    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        start_i      = 1'b0;
        load_done_i  = 1'b0;
        abort_i      = 1'b0;
        stage_done_i = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) stage_done_i = 1'b1;
        end
        if (stage_start_o) begin
            if (stage_q.size() == 0) check_eq("stage_unexpected", 1, 0);
            else check_eq("stage_idx_bank", {stage_idx_o, bank_sel_o}, stage_q.pop_front());
            last_start_cyc = cyc;
            // LS idle wait cycles, completion on the following one
            if (int'(stage_idx_o) != hold_stage) resp_cnt = LS + 1;
        end
        if (bp_mode) begin
            if (unload_en_o) begin
                unload_ready_i = rdy_phase;
                rdy_phase      = !rdy_phase;
            end else begin
                unload_ready_i = 1'b0;
                rdy_phase      = 1'b0;
            end
        end else begin
            unload_ready_i = 1'b1;
        end
        #1;
        if (unload_en_o) unl_cycles++;
        if (unload_valid_o) begin
            if (addr_q.size() == 0) check_eq("unload_unexpected", 1, 0);
            else check_eq("unload_addr", unload_addr_o, addr_q.pop_front());
        end
        if (frame_done_o) begin
            n_done++;
            if (done_q.size() == 0) check_eq("done_unexpected", 1, 0);
            else check_eq("frame_len", cyc - load_cyc, done_q.pop_front());
        end
    endtask

    task automatic run_frame(input bit bp, input bit ovr, input int hold, input bit abrt);
        int  n_stg;
        int  n_addr;
        int  done_before;
        bit  ovr_fired;
        bit  abt_fired;
        bit  t_seen;
        bit  normal;
        normal     = (hold < 0) && !abrt;
        bp_mode    = bp;
        hold_stage = hold;
        n_stg      = (hold >= 0) ? hold + 1 : STAGES;
        n_addr     = (hold >= 0) ? 0 : (abrt ? 101 : N);
        for (int s = 0; s < n_stg; s++) stage_q.push_back(s * 2 + (s % 2));
        for (int a = 0; a < n_addr; a++) addr_q.push_back(a);
        // Load_done cycle counted as 1 and frame_done cycle as 1 + 8*7 + U + 1
        if (normal) done_q.push_back(STAGES * (2 + LS) + (bp ? 2 * N : N) + 1);
        done_before = n_done;
        unl_cycles  = 0;
        ovr_fired   = 1'b0;
        abt_fired   = 1'b0;
        t_seen      = 1'b0;

        start_i = 1'b1;
        step();
        check_eq("load_en", load_en_o, 1);
        check_eq("flags_cleared", {overrun_o, timeout_o}, 0);
        step();
        step();
        load_done_i = 1'b1;
        load_cyc    = cyc;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (ovr && !ovr_fired && stage_start_o && stage_idx_o == 3'd2) begin
                start_i   = 1'b1;
                ovr_fired = 1'b1;
            end
            if (abrt && !abt_fired && unload_en_o && unload_addr_o == 8'd100) begin
                abort_i   = 1'b1;
                abt_fired = 1'b1;
            end
            if (hold >= 0 && timeout_o && !t_seen) begin
                t_seen = 1'b1;
                check_eq("timeout_latency", cyc - last_start_cyc, TIMEOUT);
                check_eq("timeout_idle", busy_o, 0);
            end
            if (!busy_o) break;
        end
        check_eq("frame_ended", busy_o, 0);
        check_eq("frame_done_count", n_done - done_before, normal ? 1 : 0);
        check_eq("stage_q_drained", stage_q.size(), 0);
        check_eq("addr_q_drained", addr_q.size(), 0);
        check_eq("overrun_flag", overrun_o, ovr);
        check_eq("timeout_flag", timeout_o, (hold >= 0) ? 1 : 0);
        if (normal) begin
            check_eq("unload_cycles", unl_cycles, bp ? 2 * N : N);
            check_eq("bank_at_end", bank_sel_o, 0);
        end
        if (abrt) begin
            check_eq("abort_reached", abt_fired, 1);
            check_eq("abort_unload_en", unload_en_o, 0);
            check_eq("abort_addr_reset", unload_addr_o, 0);
        end
        done_q.delete();
        step();
    endtask

    initial begin
        int  done_before;
        bit  found;
        step();
        step();
        check_eq("reset_outputs", all_outs(), 0);
        rst_n = 1'b1;
        step();
        check_eq("idle_outputs", all_outs(), 0);

        run_frame(1'b0, 1'b0, -1, 1'b0);
        run_frame(1'b1, 1'b0, -1, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b0);
        run_frame(1'b0, 1'b0, -1, 1'b0);
        run_frame(1'b0, 1'b0, 3, 1'b0);
        run_frame(1'b0, 1'b0, -1, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b1);

        // Reset in the middle of stage 1 with overrun_o set
        bp_mode     = 1'b0;
        hold_stage  = -1;
        done_before = n_done;
        stage_q.push_back(0);
        stage_q.push_back(3);
        start_i = 1'b1;
        step();
        step();
        load_done_i = 1'b1;
        load_cyc    = cyc;
        found       = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step();
            if (stage_start_o && stage_idx_o == 3'd1) found = 1'b1;
        end
        check_eq("reach_stage1", found, 1);
        start_i = 1'b1;
        step();
        step();
        check_eq("pre_reset_busy_ovr", {busy_o, overrun_o}, 2'b11);
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outputs", all_outs(), 0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_eq("reset_no_frame_done", n_done - done_before, 0);
        check_eq("reset_stays_idle", all_outs(), 0);
        check_eq("reset_stage_q", stage_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
